// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-bus controller between the CPU memory command outputs
// and a 256x16 synchronous RAM plus memory-mapped switches and LEDs.
// Hides the RAM's one-cycle registered read latency behind mem_ready/rd_valid.
// Optional feature macro: MEM_BUS_ERR_EN adds the bus_err pulse output.
module mem_bus_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RAM_AW = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR
`ifdef MEM_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10,
    MILL   = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  state_e state, state_next;

  cmd_e cmd;
  logic is_ram, is_led, is_sw;
  logic acc_read, acc_write;
  logic led_write, io_read;
  logic err_access;

  // Address decode and command qualification.
  always_comb begin
    cmd      = cmd_e'(mem_cmd);
    is_ram   = (mem_addr[ADDR_W-1] == 1'b0);
    is_led   = (mem_addr == LED_ADDR);
    is_sw    = (mem_addr == SW_ADDR);
    ram_addr = mem_addr[RAM_AW-1:0];
    ram_din  = write_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus handshake and RAM write strobe.
  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    acc_read   = 1'b0;
    acc_write  = 1'b0;
    ram_write  = 1'b0;
    led_write  = 1'b0;
    io_read    = 1'b0;
    err_access = 1'b0;
    unique case (state)
      IDLE: begin
        mem_ready = !reset;
        acc_read  = mem_ready && (cmd == MREAD);
        acc_write = mem_ready && (cmd == MWRITE);
        ram_write = acc_write && is_ram;
        led_write = acc_write && is_led;
        io_read   = acc_read && !is_ram;
        // Unmapped accesses, SW writes, LED reads and illegal commands.
        err_access = (mem_ready && (cmd == MILL))
                   || (acc_write && !is_ram && !is_led)
                   || (acc_read && !is_ram && !is_sw);
        if (acc_read && is_ram) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read result, valid pulse and LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
      rd_valid  <= 1'b0;
      LEDR      <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (state == RD_WAIT) begin
        read_data <= ram_dout;
        rd_valid  <= 1'b1;
      end else begin
        if (led_write) begin
          LEDR <= write_data[7:0];
        end
        if (io_read) begin
          rd_valid  <= 1'b1;
          read_data <= is_sw ? {{(DATA_W-8){1'b0}}, SW} : '0;
        end
      end
    end
  end

`ifdef MEM_BUS_ERR_EN
  // One-cycle error pulse following each faulty accepted access.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= err_access;
    end
  end
`else
  logic unused_err;
  always_comb unused_err = err_access;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: directed steps followed by randomized commands,
// checked against a transaction-level model of the controller and RAM.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic        mem_ready;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  SW;
  logic [7:0]  LEDR;
`ifdef MEM_BUS_ERR_EN
  logic        bus_err;
`endif

  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(9), .RAM_AW(8),
                 .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .mem_ready(mem_ready), .read_data(read_data),
    .rd_valid(rd_valid), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout), .SW(SW), .LEDR(LEDR)
`ifdef MEM_BUS_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read; fill port preloads contents.
  logic [15:0] ram [256];
  logic        fill_en = 1'b0;
  logic [7:0]  fill_addr = '0;
  logic [15:0] fill_data = '0;
  always @(posedge clk) begin
    if (fill_en) ram[fill_addr] <= fill_data;
    else if (ram_write) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Reference model state.
  logic [15:0] ref_mem [256];
  logic        m_busy = 1'b0;
  logic [7:0]  m_pend = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_rd = '0;
  logic [7:0]  m_led = '0;
  logic        m_err = 1'b0;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check combinational outputs, advance the
  // model across the edge, then check registered outputs.
  task automatic step(input logic rst, input logic [1:0] cmd, input logic [8:0] addr,
                      input logic [15:0] data, input logic [7:0] sw_v);
    logic rdy, ram_hit, led_hit, sw_hit;
    @(negedge clk);
    reset = rst; mem_cmd = cmd; mem_addr = addr; write_data = data; SW = sw_v;
    #1;
    rdy     = !rst && !m_busy;
    ram_hit = (addr < 9'd256);
    led_hit = (addr == 9'h100);
    sw_hit  = (addr == 9'h140);
    check("mem_ready", 16'(mem_ready), 16'(rdy));
    check("ram_write", 16'(ram_write), 16'(rdy && cmd == 2'b10 && ram_hit));
    check("ram_addr", 16'(ram_addr), 16'(addr[7:0]));
    check("ram_din", ram_din, data);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_rd = '0; m_led = '0; m_err = 1'b0;
    end else if (m_busy) begin
      m_busy = 1'b0; m_valid = 1'b1; m_rd = ref_mem[m_pend]; m_err = 1'b0;
    end else begin
      m_valid = 1'b0; m_err = 1'b0;
      if (cmd == 2'b10) begin
        if (ram_hit) ref_mem[addr[7:0]] = data;
        else if (led_hit) m_led = data[7:0];
        else m_err = 1'b1;
      end else if (cmd == 2'b01) begin
        if (ram_hit) begin
          m_busy = 1'b1; m_pend = addr[7:0];
        end else begin
          m_valid = 1'b1;
          m_rd = sw_hit ? {8'h00, sw_v} : 16'h0000;
          m_err = !sw_hit;
        end
      end else if (cmd == 2'b11) begin
        m_err = 1'b1;
      end
    end
    #1;
    check("rd_valid", 16'(rd_valid), 16'(m_valid));
    check("read_data", read_data, m_rd);
    check("LEDR", 16'(LEDR), 16'(m_led));
`ifdef MEM_BUS_ERR_EN
    check("bus_err", 16'(bus_err), 16'(m_err));
`endif
  endtask

  initial begin
    logic [1:0]  rc;
    logic [8:0]  ra;
    logic [15:0] rdat;
    int unsigned sel;

    reset = 1'b1; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; SW = '0;

    // Preload RAM and model with identical random contents while in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      fill_en = 1'b1;
      fill_addr = 8'(i);
      fill_data = 16'($urandom);
      ref_mem[i] = fill_data;
    end
    @(negedge clk);
    fill_en = 1'b0;

    // Reset then idle.
    step(1'b1, 2'b00, 9'h000, 16'h0000, 8'h00);
    step(1'b0, 2'b00, 9'h000, 16'h0000, 8'h00);
    check("idle_ready", 16'(mem_ready), 16'h0001);
    check("idle_rdata", read_data, 16'h0000);

    // RAM write then read with 2-cycle latency.
    step(1'b0, 2'b10, 9'h005, 16'hABCD, 8'h00);
    step(1'b0, 2'b01, 9'h005, 16'h0000, 8'h00);
    check("rd_wait_ready", 16'(mem_ready), 16'h0000);
    step(1'b0, 2'b00, 9'h005, 16'h0000, 8'h00);
    check("ram_rd_valid", 16'(rd_valid), 16'h0001);
    check("ram_rd_data", read_data, 16'hABCD);

    // LED write and switch read.
    step(1'b0, 2'b10, 9'h100, 16'h12A5, 8'h00);
    check("led_value", 16'(LEDR), 16'h00A5);
    step(1'b0, 2'b01, 9'h140, 16'h0000, 8'h3C);
    check("sw_valid", 16'(rd_valid), 16'h0001);
    check("sw_data", read_data, 16'h003C);

    // Unmapped and illegal commands.
    step(1'b0, 2'b01, 9'h1FF, 16'h0000, 8'h3C);
    check("unmapped_rd", read_data, 16'h0000);
    step(1'b0, 2'b10, 9'h1FF, 16'hFFFF, 8'h00);
    step(1'b0, 2'b11, 9'h100, 16'hFFFF, 8'h00);
    check("led_kept", 16'(LEDR), 16'h00A5);

    // Stall: write held during RD_WAIT commits in the rd_valid cycle.
    step(1'b0, 2'b01, 9'h010, 16'h0000, 8'h00);
    step(1'b0, 2'b10, 9'h011, 16'h5A5A, 8'h00);
    step(1'b0, 2'b10, 9'h011, 16'h5A5A, 8'h00);
    step(1'b0, 2'b01, 9'h011, 16'h0000, 8'h00);
    step(1'b0, 2'b00, 9'h000, 16'h0000, 8'h00);
    check("stall_rd_data", read_data, 16'h5A5A);

    // Reset mid-read abandons the read.
    step(1'b1, 2'b00, 9'h000, 16'h0000, 8'h00);
    step(1'b0, 2'b01, 9'h020, 16'h0000, 8'h00);
    step(1'b1, 2'b00, 9'h020, 16'h0000, 8'h00);
    check("rst_mid_valid", 16'(rd_valid), 16'h0000);
    check("rst_mid_data", read_data, 16'h0000);
    step(1'b0, 2'b00, 9'h000, 16'h0000, 8'h00);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      rc = (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : (sel < 8) ? 2'b00 : 2'b11;
      sel = $urandom_range(0, 5);
      ra = (sel < 3) ? {5'b00000, 4'($urandom)} :
           (sel == 3) ? 9'h100 : (sel == 4) ? 9'h140 : 9'($urandom);
      rdat = 16'($urandom);
      step(($urandom_range(0, 39) == 0), rc, ra, rdat, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
